// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: N-digit BCD up/down counter with clear, load, enable and chainable terminal count
module bcd_updown_counter_n #(
    parameter int DIGITS   = 4,
    parameter bit LOAD_CHK = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
    logic [4*DIGITS-1:0] q_q, q_d, cnt_v, ld_v;
    logic                wrap_q, wrap_d, err_q, err_d, cy, ld_bad;
    logic [3:0]          nib;
    // ripple the carry/borrow digit by digit; out-of-range nibbles take the wrap value
    always_comb begin
        cnt_v  = q_q;
        ld_v   = d;
        ld_bad = 1'b0;
        cy     = 1'b1;
        nib    = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = q_q[4*k +: 4];
            if (cy) cnt_v[4*k +: 4] = up ? (nib >= 4'd9 ? 4'd0 : nib + 4'd1) : ((nib == 4'd0 || nib > 4'd9) ? 4'd9 : nib - 4'd1);
            cy = cy & (up ? nib >= 4'd9 : nib == 4'd0);
            if (LOAD_CHK && d[4*k +: 4] > 4'd9) begin
                ld_v[4*k +: 4] = 4'd0;
                ld_bad         = 1'b1;
            end
        end
    end
    // clear beats load beats enabled count; both pulses fall unless re-triggered
    always_comb begin
        q_d    = clear ? '0 : load ? ld_v : en ? cnt_v : q_q;
        wrap_d = !clear && !load && en && cy;
        err_d  = !clear && load && ld_bad;
    end
    // state registers, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end
    assign q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;
    assign tc       = en & (up ? q_q == NINES : q_q == '0);
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: scoreboard bench for the BCD up/down counter and a two-stage cascade
module tb_bcd_updown_counter_n;
    typedef struct {
        string       nm;
        int          id;
        logic [15:0] q;
        logic        w;
        logic        e;
        logic        t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_s [4];
    logic        up_s [4];
    logic        clr_s [4];
    logic        ld_s [4];
    logic [15:0] d_s [4];
    logic [7:0]  q2, qc0, qc1, qr;
    logic [15:0] q4;
    logic        t2, w2, e2, t4, w4, e4, tc0, wc0, ec0, tc1, wc1, ec1, tr, wr, er;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.DIGITS(2), .LOAD_CHK(1'b1)) u2 (
        .clk(clk), .reset(reset), .en(en_s[0]), .up(up_s[0]), .clear(clr_s[0]), .load(ld_s[0]),
        .d(d_s[0][7:0]), .q(q2), .tc(t2), .wrap(w2), .load_err(e2));
    bcd_updown_counter_n #(.DIGITS(4), .LOAD_CHK(1'b1)) u4 (
        .clk(clk), .reset(reset), .en(en_s[1]), .up(up_s[1]), .clear(clr_s[1]), .load(ld_s[1]),
        .d(d_s[1]), .q(q4), .tc(t4), .wrap(w4), .load_err(e4));
    bcd_updown_counter_n #(.DIGITS(2), .LOAD_CHK(1'b1)) uc0 (
        .clk(clk), .reset(reset), .en(en_s[2]), .up(up_s[2]), .clear(clr_s[2]), .load(ld_s[2]),
        .d(d_s[2][7:0]), .q(qc0), .tc(tc0), .wrap(wc0), .load_err(ec0));
    bcd_updown_counter_n #(.DIGITS(2), .LOAD_CHK(1'b1)) uc1 (
        .clk(clk), .reset(reset), .en(tc0), .up(up_s[2]), .clear(clr_s[2]), .load(ld_s[2]),
        .d(d_s[2][15:8]), .q(qc1), .tc(tc1), .wrap(wc1), .load_err(ec1));
    bcd_updown_counter_n #(.DIGITS(2), .LOAD_CHK(1'b0)) ur (
        .clk(clk), .reset(reset), .en(en_s[3]), .up(up_s[3]), .clear(clr_s[3]), .load(ld_s[3]),
        .d(d_s[3][7:0]), .q(qr), .tc(tr), .wrap(wr), .load_err(er));

    function automatic logic [15:0] bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(string nm, int id, logic e, logic u, logic c, logic l, logic [15:0] dv,
                        logic [15:0] eq, logic ew, logic ee, logic et);
        exp_t x;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            en_s[k] = 1'b0; up_s[k] = 1'b0; clr_s[k] = 1'b0; ld_s[k] = 1'b0; d_s[k] = '0;
        end
        en_s[id] = e; up_s[id] = u; clr_s[id] = c; ld_s[id] = l; d_s[id] = dv;
        x.nm = nm; x.id = id; x.q = eq; x.w = ew; x.e = ee; x.t = et;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [15:0] aq;
        logic        aw, ae, at;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                x = sb.pop_front();
                case (x.id)
                    0:       begin aq = {8'h0, q2};  aw = w2;  ae = e2;  at = t2;  end
                    1:       begin aq = q4;          aw = w4;  ae = e4;  at = t4;  end
                    2:       begin aq = {qc1, qc0};  aw = wc1; ae = ec1; at = tc1; end
                    default: begin aq = {8'h0, qr};  aw = wr;  ae = er;  at = tr;  end
                endcase
                chk($sformatf("%s.q", x.nm), aq, x.q);
                chk($sformatf("%s.wrap", x.nm), 16'(aw), 16'(x.w));
                chk($sformatf("%s.load_err", x.nm), 16'(ae), 16'(x.e));
                chk($sformatf("%s.tc", x.nm), 16'(at), 16'(x.t));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin : stim
        for (int k = 0; k < 4; k++) begin
            en_s[k] = 1'b0; up_s[k] = 1'b0; clr_s[k] = 1'b0; ld_s[k] = 1'b0; d_s[k] = '0;
        end
        #1;
        chk("rst_q2", {8'h0, q2}, 16'h0);
        chk("rst_q4", q4, 16'h0);
        chk("rst_wrap", 16'(w2), 16'h0);
        chk("rst_err", 16'(e2), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        // two-digit count up through the rollover
        for (int v = 1; v <= 101; v++)
            step($sformatf("up%0d", v), 0, 1, 1, 0, 0, 0, bcd(v % 100), v == 100, 0, (v % 100) == 99);
        // load 10 and count down through 00 to 99
        step("ld10", 0, 1, 0, 0, 1, 16'h10, 16'h10, 0, 0, 0);
        for (int k = 1; k <= 11; k++)
            step($sformatf("dn%0d", k), 0, 1, 0, 0, 0, 0, bcd((110 - k) % 100), k == 11, 0, k == 10);
        step("dn_hold", 0, 0, 0, 0, 0, 0, 16'h99, 0, 0, 0);
        // four digits: checked load, terminal count, wrap both ways
        step("ld1A39", 1, 1, 1, 0, 1, 16'h1A39, 16'h1039, 0, 1, 0);
        step("err_drop", 1, 0, 1, 0, 0, 0, 16'h1039, 0, 0, 0);
        step("ld9999", 1, 1, 1, 0, 1, 16'h9999, 16'h9999, 0, 0, 1);
        step("up_wrap4", 1, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 0);
        step("dn_wrap4", 1, 1, 0, 0, 0, 0, 16'h9999, 1, 0, 0);
        step("dn9998", 1, 1, 0, 0, 0, 0, 16'h9998, 0, 0, 0);
        step("ld00F0", 1, 0, 0, 0, 1, 16'h00F0, 16'h0000, 0, 1, 0);
        step("clr_ld", 1, 0, 0, 1, 1, 16'hAAAA, 16'h0000, 0, 0, 0);
        // clear over load over count
        step("ld47", 0, 0, 0, 0, 1, 16'h47, 16'h47, 0, 0, 0);
        step("clr_win", 0, 1, 1, 1, 1, 16'h12, 16'h00, 0, 0, 0);
        step("ld_win", 0, 1, 1, 0, 1, 16'h12, 16'h12, 0, 0, 0);
        step("ld99_noen", 0, 0, 1, 0, 1, 16'h99, 16'h99, 0, 0, 0);
        // asynchronous reset between edges
        step("ld55", 0, 0, 0, 0, 1, 16'h55, 16'h55, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            en_s[k] = 1'b0; ld_s[k] = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("async_q", {8'h0, q2}, 16'h0);
        chk("async_wrap", 16'(w2), 16'h0);
        chk("async_err", 16'(e2), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 0, 1, 1, 0, 0, 0, 16'h01, 0, 0, 0);
        // raw load without validation, out-of-range digits must not stick
        step("rawld3C", 3, 0, 1, 0, 1, 16'h3C, 16'h3C, 0, 0, 0);
        step("raw_up", 3, 1, 1, 0, 0, 0, 16'h40, 0, 0, 0);
        step("rawld3C_b", 3, 0, 0, 0, 1, 16'h3C, 16'h3C, 0, 0, 0);
        step("raw_dn", 3, 1, 0, 0, 0, 0, 16'h39, 0, 0, 0);
        step("rawldF0", 3, 0, 0, 0, 1, 16'hF0, 16'hF0, 0, 0, 0);
        step("raw_dnF0", 3, 1, 0, 0, 0, 0, 16'h99, 0, 0, 0);
        step("raw_upwrap", 3, 1, 1, 0, 0, 0, 16'h00, 1, 0, 0);
        // cascaded pair counts 0000..9999 and rolls
        for (int v = 1; v <= 10001; v++)
            step("casc", 2, 1, 1, 0, 0, 0, bcd(v % 10000), v == 10000, 0, (v % 10000) == 9999);
        @(negedge clk);
        for (int k = 0; k < 4; k++) en_s[k] = 1'b0;
        @(posedge clk);
        #2;
        chk("sb_drain", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
